// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 4-bit CPU sequencer.
//   - instruction field widths
//   - opcode and ALU-operation encodings
//   - sequencer state enum and the execute-strobe bundle
package cpu_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int OPC_WIDTH  = 4;
  localparam int OPR_WIDTH  = 4;

  localparam logic [OPC_WIDTH-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_WIDTH-1:0] OP_LDI = 4'h1;
  localparam logic [OPC_WIDTH-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_WIDTH-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_WIDTH-1:0] OP_JMP = 4'h4;
  localparam logic [OPC_WIDTH-1:0] OP_JZ  = 4'h5;
  localparam logic [OPC_WIDTH-1:0] OP_OUT = 4'h6;
  localparam logic [OPC_WIDTH-1:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } cu_state_e;

  // Everything an instruction can request in its EXECUTE cycle.
  typedef struct packed {
    logic       acc_load;
    logic [1:0] alu_op;
    logic       pc_load;
    logic       out_load;
    logic       halt;
  } strobe_t;

endpackage

// File: rtl/control_unit_instr_decoder.sv
// instr_decoder: purely combinational opcode decode.
// Ports:
//   i_opcode    - instruction bits [7:4]
//   i_zero_flag - registered accumulator==0 flag, only consulted by JZ
//   o_strb      - requested strobe bundle (not yet qualified by state)
// Reserved opcodes 7..E fall through to the all-zero bundle, i.e. NOP.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [OPC_WIDTH-1:0] i_opcode,
  input  logic                 i_zero_flag,
  output strobe_t              o_strb
);

  always_comb begin
    o_strb = '0;
    case (i_opcode)
      OP_LDI: begin
        o_strb.acc_load = 1'b1;
        o_strb.alu_op   = ALU_PASS;
      end
      OP_ADD: begin
        o_strb.acc_load = 1'b1;
        o_strb.alu_op   = ALU_ADD;
      end
      OP_SUB: begin
        o_strb.acc_load = 1'b1;
        o_strb.alu_op   = ALU_SUB;
      end
      OP_JMP:  o_strb.pc_load  = 1'b1;
      OP_JZ:   o_strb.pc_load  = i_zero_flag;
      OP_OUT:  o_strb.out_load = 1'b1;
      OP_HLT:  o_strb.halt     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 4-bit CPU.
// Fixed three cycles per instruction; HLT parks the machine until reset.
// Ports:
//   clk, reset_n        - clock (rising edge), async active-low reset
//   pc_value            - current PC from the program counter
//   rom_data            - registered ROM word, valid one cycle after rom_addr
//   zero_flag           - registered accumulator==0 flag (JZ only)
//   step                - (CU_SINGLE_STEP_EN only) single-step pulse
//   rom_addr            - ROM read address (always the PC)
//   pc_inc/pc_load/pc_in- program counter controls
//   acc_load/alu_op     - accumulator write strobe and ALU operation
//   out_load            - output register write strobe
//   ir                  - instruction register (debug visibility)
//   halted              - high while parked in HALT
// Optional build macro: CU_SINGLE_STEP_EN adds the step input and makes
// FETCH wait for a step pulse before each instruction.
//
// state   | meaning
// --------+---------------------------------------------------------
// FETCH   | ROM addressed with PC; no strobes (waits for step if enabled)
// DECODE  | ROM word captured into ir; PC incremented
// EXECUTE | one strobe group from the decoded ir
// HALT    | absorbing; halted=1, no strobes, until reset
module control_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4,
  parameter int OPR_W  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_W-1:0]      pc_value,
  input  logic [OPC_W+OPR_W-1:0] rom_data,
  input  logic                   zero_flag,
`ifdef CU_SINGLE_STEP_EN
  input  logic                   step,
`endif
  output logic [ADDR_W-1:0]      rom_addr,
  output logic                   pc_inc,
  output logic                   pc_load,
  output logic [ADDR_W-1:0]      pc_in,
  output logic                   acc_load,
  output logic [1:0]             alu_op,
  output logic                   out_load,
  output logic [OPC_W+OPR_W-1:0] ir,
  output logic                   halted
);

  cu_state_e               r_state;
  cu_state_e               w_next;
  logic [OPC_W+OPR_W-1:0]  r_ir;
  strobe_t                 w_strb;
  logic                    w_exec;
  logic                    w_go;

  instr_decoder u_dec (
    .i_opcode    (r_ir[OPC_W+OPR_W-1:OPR_W]),
    .i_zero_flag (zero_flag),
    .o_strb      (w_strb)
  );

`ifdef CU_SINGLE_STEP_EN
  assign w_go = step;
`else
  assign w_go = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_ir <= rom_data;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   w_next = w_go ? DECODE : FETCH;
      DECODE:  w_next = EXECUTE;
      EXECUTE: w_next = w_strb.halt ? HALT : FETCH;
      HALT:    w_next = HALT;
      default: w_next = FETCH;
    endcase
  end

  // All outputs derive from r_state/r_ir only; rom_data never reaches them.
  assign w_exec   = (r_state == EXECUTE);
  assign rom_addr = pc_value;
  assign pc_inc   = (r_state == DECODE);
  assign pc_load  = w_exec & w_strb.pc_load;
  assign pc_in    = r_ir[ADDR_W-1:0];
  assign acc_load = w_exec & w_strb.acc_load;
  assign alu_op   = acc_load ? w_strb.alu_op : ALU_PASS;
  assign out_load = w_exec & w_strb.out_load;
  assign ir       = r_ir;
  assign halted   = (r_state == HALT);

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Fetch/decode/execute sequencer for the 4-bit CPU.
- Sits between the program counter and the ROM/datapath:
  - consumes the PC value and drives its pc_inc/pc_load/pc_in controls;
  - latches ROM words into an instruction register;
  - issues one-cycle control strobes to the accumulator/ALU/output register.
- Fixed 3-cycle instruction timing; HLT parks the machine until reset.

Parameters:
ADDR_W, 4, PC/ROM address width
OPC_W, 4, opcode field width (instruction bits [7:4])
OPR_W, 4, operand field width (instruction bits [3:0]; immediate or jump target)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
pc_value  input  ADDR_W  current PC from program counter
rom_data  input  OPC_W+OPR_W  ROM read data, registered ROM, valid 1 cycle after rom_addr
zero_flag  input  1  accumulator==0, registered in datapath
rom_addr  output  ADDR_W  ROM read address
pc_inc  output  1  increment PC this edge
pc_load  output  1  load pc_in this edge
pc_in  output  ADDR_W  jump target
acc_load  output  1  accumulator write strobe
alu_op  output  2  00 pass imm, 01 add, 10 sub
out_load  output  1  output-register write strobe
ir  output  OPC_W+OPR_W  instruction register (debug visibility)
halted  output  1  high in HALT state

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low. reset_n low → state=FETCH, ir=8'h00, halted=0; all strobes 0 combinationally.
- Outputs are combinational from registered state and ir only (zero_flag used only for JZ and is itself registered upstream). No combinational path from rom_data to outputs.
- States: FETCH → DECODE → EXECUTE → FETCH; HALT absorbing.
- FETCH:
  - rom_addr=pc_value; no strobes.
  - Next: DECODE.
- DECODE:
  - ir <= rom_data at end of cycle.
  - pc_inc=1: PC advances once per instruction; 4-bit wrap 15→0 is the PC's concern, no special case here.
  - Next: EXECUTE.
- EXECUTE, decode on ir[7:4]; exactly one strobe group per cycle:
  - 0 NOP: none.
  - 1 LDI: acc_load=1, alu_op=00.
  - 2 ADD: acc_load=1, alu_op=01.
  - 3 SUB: acc_load=1, alu_op=10.
  - 4 JMP: pc_load=1, pc_in=ir[3:0].
  - 5 JZ: pc_load=zero_flag, pc_in=ir[3:0].
  - 6 OUT: out_load=1.
  - F HLT: next=HALT.
  - 7–E: reserved, execute as NOP.
  - Next: FETCH, except HLT.
- Invariants:
  - pc_in=ir[3:0] at all times; value only meaningful when pc_load=1.
  - pc_inc and pc_load never high in the same cycle, so the PC's load>inc priority is never exercised.
  - alu_op defaults to 00 when acc_load=0.
- HALT:
  - halted=1, all strobes 0, rom_addr=pc_value.
  - Stays in HALT until reset_n is asserted; PC is frozen at HLT address+1.
- JMP to own address loops indefinitely (legal).
- Reset asserted mid-instruction: immediate return to FETCH; any partially decoded instruction is discarded; no strobe is emitted while reset_n is low.

Optional Feature:
- Macro: CU_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit, synchronous pulse from debounced button).
  - FETCH holds until step=1, then proceeds to DECODE; one instruction per step pulse.
  - step while in DECODE/EXECUTE/HALT is ignored.
- Undefined: no step port; FETCH always advances next cycle.

Decomposition:
- Package cpu_pkg:
  - opcode constants OP_NOP..OP_HLT;
  - ALU_PASS/ALU_ADD/ALU_SUB encodings;
  - state enum (FETCH, DECODE, EXECUTE, HALT);
  - field widths.
- Sub-module instr_decoder: combinational, takes ir[7:4] and zero_flag, returns the strobe bundle; control_unit gates it with state==EXECUTE.

Test Plan:
- Reset release, ROM[0]=8'h1A (LDI 10) → pc_inc in cycle 2, acc_load=1 and alu_op=00 in cycle 3, back to FETCH in cycle 4.
- Program LDI 3; ADD 2; OUT; HLT → out_load once at cycle 9; halted=1 from cycle 13; PC holds 4; no further strobes for 50 cycles.
- JZ 9 with zero_flag=1 → pc_load=1, pc_in=9, pc_inc=0 in EXECUTE; repeat with zero_flag=0 → pc_load=0, next fetch address is original+1.
- JMP 0 at address 15 → pc_inc wraps PC to 0 in DECODE, then pc_load to 0; loop verified over 3 iterations.
- reset_n pulsed low during EXECUTE of ADD → acc_load drops asynchronously, state=FETCH, ir=0; fetch restarts at PC=0.
- CU_SINGLE_STEP_EN defined: no step for 20 cycles → remains in FETCH with zero strobes; one step pulse → exactly one instruction executes.
